// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one sequential multiplier between NUM_REQ
// requesters and returns each product on a single tagged response channel.
module mult_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int WW         = $clog2(DATA_WIDTH) + 1,
  parameter int IDW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WW-1:0]         req_width,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [IDW-1:0]                resp_id,
  output logic [2*DATA_WIDTH-1:0]       resp_result,
  output logic                          resp_err,
  output logic                          mult_op_enable,
  output logic [WW-1:0]                 mult_in_width,
  output logic [DATA_WIDTH-1:0]         mult_in_a,
  output logic [DATA_WIDTH-1:0]         mult_in_b,
  input  logic [2*DATA_WIDTH-1:0]       mult_result,
  input  logic                          mult_finish
);

  localparam int WDOG_LIMIT = DATA_WIDTH + 8;
  localparam int WDW        = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          arb_idx;
  logic [IDW-1:0]          grant_id;
  logic                    grant_vld;
  logic [WW-1:0]           sel_width;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;
  logic [IDW-1:0]          op_id;
  logic [WW-1:0]           op_width;
  logic [DATA_WIDTH-1:0]   op_a, op_b;
  logic [WDW-1:0]          wdog;
  logic                    wdog_expired;
  logic [2*DATA_WIDTH-1:0] res_q;
  logic                    err_q;

  function automatic logic width_legal(input logic [WW-1:0] w);
    return (w >= WW'(2)) && (w <= WW'(DATA_WIDTH));
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + IDW'(1);
  endfunction

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_vld && req_valid[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx;
      end
    end
  end

  assign sel_width    = req_width[int'(grant_id)*WW +: WW];
  assign sel_a        = req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b        = req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign wdog_expired = (wdog == WDW'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          if (!rst) req_ready[grant_id] = 1'b1;
          state_nxt = width_legal(sel_width) ? RUN : RESP;
        end
      end
      RUN:     if (mult_finish || wdog_expired) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on grant; result/error capture on finish or watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      op_id    <= '0;
      op_width <= '0;
      op_a     <= '0;
      op_b     <= '0;
      wdog     <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_id    <= grant_id;
            op_width <= sel_width;
            op_a     <= sel_a;
            op_b     <= sel_b;
            rr_ptr   <= next_ptr(grant_id);
            wdog     <= '0;
            res_q    <= '0;
            err_q    <= !width_legal(sel_width);
          end
        end
        RUN: begin
          wdog <= wdog + WDW'(1);
          if (mult_finish) begin
            res_q <= mult_result;
            err_q <= 1'b0;
          end else if (wdog_expired) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Enable is decoded from state so an asynchronous reset drops it at once.
  assign mult_op_enable = (state == RUN);
  assign mult_in_width  = op_width;
  assign mult_in_a      = op_a;
  assign mult_in_b      = op_b;
  assign resp_valid     = (state == RESP);
  assign resp_id        = op_id;
  assign resp_result    = res_q;
  assign resp_err       = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: stub multiplier, round-robin reference model and
// directed plus randomized traffic.
module tb_mult_arbiter;
  localparam int DW   = 32;
  localparam int N    = 4;
  localparam int WW   = 6;
  localparam int IDW  = 2;
  localparam int WDOG = DW + 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    vld = '0;
  int              w_arr[N];
  logic [DW-1:0]   a_arr[N];
  logic [DW-1:0]   b_arr[N];
  logic [N*WW-1:0] req_width;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [IDW-1:0]  resp_id;
  logic [2*DW-1:0] resp_result;
  logic            resp_err;
  logic            mult_op_enable;
  logic [WW-1:0]   mult_in_width;
  logic [DW-1:0]   mult_in_a, mult_in_b;
  logic [2*DW-1:0] mult_result;
  logic            mult_finish;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_width = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      req_width[i*WW +: WW] = WW'(w_arr[i]);
      req_a[i*DW +: DW]     = a_arr[i];
      req_b[i*DW +: DW]     = b_arr[i];
    end
  end

  mult_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(vld), .req_ready(req_ready), .req_width(req_width),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err),
    .mult_op_enable(mult_op_enable), .mult_in_width(mult_in_width),
    .mult_in_a(mult_in_a), .mult_in_b(mult_in_b),
    .mult_result(mult_result), .mult_finish(mult_finish)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] m;
    m = (w >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (64'(a) & m) * (64'(b) & m);
  endfunction

  // Stub multiplier: integer product of width-masked operands, finish
  // in_width+3 cycles after enable rises, cleared while enable is low.
  int          scnt = 0;
  logic        sfin = 1'b0;
  logic [63:0] sres = '0;
  bit          stub_never = 1'b0;
  bit          glitch_fin = 1'b0;

  always @(posedge clk) begin
    if (!mult_op_enable) begin
      scnt <= 0;
      sfin <= 1'b0;
    end else if (!stub_never) begin
      scnt <= scnt + 1;
      if (scnt == int'(mult_in_width) + 2) begin
        sfin <= 1'b1;
        sres <= prod(mult_in_a, mult_in_b, int'(mult_in_width));
      end
    end
  end

  assign mult_finish = sfin | glitch_fin;
  assign mult_result = glitch_fin ? 64'hA5A5_5A5A_DEAD_BEEF : sres;

  // Reference model: round-robin pointer, one outstanding transaction.
  int          cyc = 0, busy = 0, mptr = 0, hs_cyc = 0, exp_id = 0;
  int          ops_seen = 0, run_len = 0, last_run = 0, low_run = 0, resp_cnt = 0;
  bit          exp_err = 0, exp_illegal = 0, prev_fin = 0, prev_en = 0;
  logic [63:0] exp_res = '0, last_res = '0;
  int          grant_seen[N];
  int          grant_ack[N];
  int          glog[$];

  always @(negedge clk) begin
    if (rst) begin
      busy = 0; mptr = 0; ops_seen = 0; low_run = 0; run_len = 0;
      prev_fin = 0; prev_en = 0;
    end else begin
      int g;
      logic [N-1:0] m;
      cyc++;
      if (prev_fin) chk("fin_to_resp", resp_valid, 1);
      prev_fin = mult_finish & mult_op_enable;
      if (mult_op_enable) begin
        if (!prev_en) begin
          if (ops_seen > 0) chk("en_gap_ge2", low_run >= 2, 1);
          ops_seen++;
        end
        run_len++;
        low_run = 0;
      end else begin
        if (prev_en) last_run = run_len;
        run_len = 0;
        low_run++;
      end
      prev_en = mult_op_enable;

      if (busy != 0) chk("ready_while_busy", req_ready, 0);
      else begin
        g = -1;
        for (int i = 0; i < N; i++)
          if (g < 0 && vld[(mptr + i) % N]) g = (mptr + i) % N;
        m = (g >= 0) ? (N'(1) << g) : '0;
        chk("grant", req_ready, m);
        if (g >= 0) begin
          busy        = 1;
          hs_cyc      = cyc;
          mptr        = (g + 1) % N;
          grant_seen[g]++;
          glog.push_back(g);
          exp_id      = g;
          exp_illegal = (w_arr[g] < 2) || (w_arr[g] > DW);
          exp_err     = exp_illegal || stub_never;
          exp_res     = exp_err ? 64'd0 : prod(a_arr[g], b_arr[g], w_arr[g]);
        end
      end

      if (busy != 0 && cyc == hs_cyc + 1) begin
        if (exp_illegal) chk("illegal_resp_next", {resp_valid, mult_op_enable}, 2'b10);
        else             chk("enable_next", {mult_op_enable, resp_valid}, 2'b10);
      end

      if (resp_valid) begin
        chk("resp_owned", busy, 1);
        chk("en_low_in_resp", mult_op_enable, 0);
        if (resp_ready && busy != 0) begin
          chk("resp_id", resp_id, exp_id);
          chk("resp_err", resp_err, exp_err);
          chk("resp_result", resp_result, exp_res);
          last_res = resp_result;
          busy     = 0;
          resp_cnt++;
        end
      end
    end
  end

  int mode = 0;

  function automatic int rand_w();
    int r;
    int p;
    r = $urandom_range(0, 9);
    p = $urandom_range(0, 2);
    if (r == 0) return (p == 0) ? 0 : (p == 1) ? 1 : DW + 1;
    return $urandom_range(2, DW);
  endfunction

  task automatic new_op(input int i, input int w);
    w_arr[i] = w;
    a_arr[i] = $urandom;
    b_arr[i] = $urandom;
    vld[i]   = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (grant_seen[i] != grant_ack[i]) begin
        grant_ack[i] = grant_seen[i];
        if (mode == 2) new_op(i, DW);
        else           vld[i] = 1'b0;
      end else if (mode == 1) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) new_op(i, rand_w());
        else if (vld[i] && $urandom_range(0, 31) == 0) vld[i] = 1'b0;
      end
    end
    if (mode == 1) resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n;
    n = 0;
    while (resp_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (resp_cnt < target) chk("resp_timeout", resp_cnt, target);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic sync_ack();
    for (int i = 0; i < N; i++) grant_ack[i] = grant_seen[i];
  endtask

  initial begin
    int base, start, n, o, rc, gs;
    for (int i = 0; i < N; i++) begin
      w_arr[i] = 0; a_arr[i] = '0; b_arr[i] = '0;
      grant_seen[i] = 0; grant_ack[i] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {req_ready, resp_valid, resp_id, resp_err, mult_op_enable, mult_in_width}, '0);
    chk("rst_result", resp_result, '0);
    chk("rst_operands", {mult_in_a, mult_in_b}, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request, requester 0, w=8.
    base = grant_seen[0];
    w_arr[0] = 8; a_arr[0] = 32'h13; b_arr[0] = 32'h5; vld[0] = 1'b1;
    wait_resp(resp_cnt + 1, 60);
    chk("t1_ready_pulses", grant_seen[0] - base, 1);
    chk("t1_result", last_res, 64'h5F);
    chk("t1_enable_cycles", last_run, 8 + 4);

    // All requesters valid continuously at full width.
    do_reset();
    start = glog.size();
    for (int i = 0; i < N; i++) new_op(i, DW);
    mode = 2;
    wait_resp(resp_cnt + 5, 400);
    mode = 0;
    vld  = '0;
    sync_ack();
    for (int k = 0; k < 5; k++)
      chk("t3_order", (start + k < glog.size()) ? glog[start + k] : -1, k % N);

    // Response back-pressure for 10 cycles with a competing request.
    resp_ready = 1'b0;
    new_op(1, 16);
    n = 0;
    while (!resp_valid && n < 100) begin
      step();
      n++;
    end
    chk("t4_resp_seen", resp_valid, 1);
    new_op(3, 10);
    for (int k = 0; k < 10; k++) begin
      glitch_fin = (k >= 3 && k < 6);
      @(negedge clk);
      chk("t4_hold", {resp_valid, resp_id, resp_err, resp_result, req_ready, mult_op_enable},
          {1'b1, IDW'(exp_id), exp_err, exp_res, 4'b0, 1'b0});
    end
    glitch_fin = 1'b0;
    resp_ready = 1'b1;
    wait_resp(resp_cnt + 2, 100);

    // Illegal widths never enable the multiplier.
    o = ops_seen;
    new_op(2, 1);
    wait_resp(resp_cnt + 1, 20);
    new_op(0, DW + 1);
    wait_resp(resp_cnt + 1, 20);
    new_op(1, 0);
    wait_resp(resp_cnt + 1, 20);
    chk("t5_no_enable", ops_seen, o);

    // Watchdog on a multiplier that never finishes, then normal service.
    stub_never = 1'b1;
    new_op(3, 8);
    wait_resp(resp_cnt + 1, 100);
    chk("t6_wdog_run_len", last_run, WDOG);
    stub_never = 1'b0;
    new_op(1, 20);
    wait_resp(resp_cnt + 1, 100);

    // Asynchronous reset five cycles into RUN.
    new_op(2, DW);
    n = 0;
    while (!mult_op_enable && n < 10) begin
      step();
      n++;
    end
    repeat (5) step();
    rc = resp_cnt;
    #1 rst = 1'b1;
    #1;
    chk("t7_async_ctrl", {req_ready, resp_valid, resp_id, resp_err, mult_op_enable, mult_in_width}, '0);
    chk("t7_async_result", resp_result, '0);
    chk("t7_async_operands", {mult_in_a, mult_in_b}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t7_no_resp", resp_cnt, rc);
    gs = glog.size();
    new_op(2, 12);
    new_op(3, 12);
    wait_resp(rc + 2, 100);
    chk("t7_first_grant", (gs < glog.size()) ? glog[gs] : -1, 2);

    // Randomized traffic with random back-pressure.
    mode = 1;
    repeat (600) step();
    mode = 0;
    vld  = '0;
    sync_ack();
    resp_ready = 1'b1;
    n = 0;
    while (busy != 0 && n < 200) begin
      step();
      n++;
    end
    chk("t8_drained", busy, 0);

    // Stray finish while idle must not produce a response.
    glitch_fin = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("t9_idle_glitch", {resp_valid, mult_op_enable, req_ready}, '0);
    glitch_fin = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
